axis_switch_crossbar: RTL and testbench

AXIS_SWITCH_CROSSBAR -- requirements
Module: axis_switch_crossbar

---
 rtl/axis_switch_crossbar_pkg.sv | 24 ++
 rtl/axis_crossbar_master_port.sv | 52 +++++
 rtl/axis_switch_crossbar.sv | 139 +++++++++++++
 tb/tb_axis_switch_crossbar.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_switch_crossbar_pkg.sv
// Shared definitions for the AXI-Stream crossbar: per-master FSM states and
// the destination window decode used to route slave streams to masters.
package axis_switch_crossbar_pkg;

  localparam logic [0:0] ST_IDLE        = 1'b0;
  localparam logic [0:0] ST_TRANSACTION = 1'b1;

  typedef enum logic [0:0] {
    IDLE        = ST_IDLE,
    TRANSACTION = ST_TRANSACTION
  } port_state_e;

  // Master idx owns [base + idx*stride, base + idx*stride + range].
  function automatic logic dest_in_window(input logic [31:0] dest,
                                          input logic [31:0] base,
                                          input logic [31:0] stride,
                                          input logic [31:0] range,
                                          input logic [31:0] idx);
    logic [31:0] lo;
    lo = base + idx * stride;
    return (dest >= lo) && ((dest - lo) <= range);
  endfunction

endpackage

// File: rtl/axis_crossbar_master_port.sv
// Per-master round-robin arbiter and IDLE/TRANSACTION FSM. The grant register
// doubles as the round-robin pointer: it only changes when a new grant is made.
module axis_crossbar_master_port
  import axis_switch_crossbar_pkg::*;
#(
  parameter int NSLAVES  = 4,
  parameter int HAS_LAST = 1,
  parameter int SW       = 2
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [NSLAVES-1:0] req,
  input  logic [NSLAVES-1:0] s_valid,
  input  logic [NSLAVES-1:0] s_last,
  input  logic               m_ready,
  output port_state_e        state,
  output logic [SW-1:0]      grant
);

  logic [SW-1:0] pick;
  logic          any_req;
  logic          end_of_packet;

  // Search starts one past the previous grant and wraps.
  always_comb begin
    pick    = grant;
    any_req = 1'b0;
    for (int k = 1; k <= NSLAVES; k++) begin
      if (!any_req && req[(int'(grant) + k) % NSLAVES]) begin
        any_req = 1'b1;
        pick    = SW'((int'(grant) + k) % NSLAVES);
      end
    end
  end

  assign end_of_packet = s_valid[grant] && m_ready && ((HAS_LAST == 0) || s_last[grant]);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      grant <= SW'(NSLAVES - 1);
    end else if (state == IDLE) begin
      if (any_req) begin
        grant <= pick;
        state <= TRANSACTION;
      end
    end else if (end_of_packet) begin
      state <= IDLE;
    end
  end

endmodule

// File: rtl/axis_switch_crossbar.sv
// AXI-Stream N x M crossbar: dest decode, per-master arbitration, a purely
// combinational granted datapath and per-slave DROP for unmapped streams.
// Handshake: a beat moves on an edge where valid and ready are both high.
module axis_switch_crossbar
  import axis_switch_crossbar_pkg::*;
#(
  parameter int NSLAVES     = 4,
  parameter int NMASTERS    = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_WIDTH  = 8,
  parameter int HAS_DEST    = 1,
  parameter int HAS_ID      = 0,
  parameter int HAS_LAST    = 1,
  parameter int DEST_BASE   = 0,
  parameter int DEST_STRIDE = 1,
  parameter int DEST_RANGE  = 0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NSLAVES-1:0]             s_valid,
  output logic [NSLAVES-1:0]             s_ready,
  input  logic [NSLAVES*DATA_WIDTH-1:0]  s_data,
  input  logic [NSLAVES*DEST_WIDTH-1:0]  s_dest,
  input  logic [NSLAVES*ID_WIDTH-1:0]    s_id,
  input  logic [NSLAVES-1:0]             s_last,
  output logic [NMASTERS-1:0]            m_valid,
  input  logic [NMASTERS-1:0]            m_ready,
  output logic [NMASTERS*DATA_WIDTH-1:0] m_data,
  output logic [NMASTERS*DEST_WIDTH-1:0] m_dest,
  output logic [NMASTERS*ID_WIDTH-1:0]   m_id,
  output logic [NMASTERS-1:0]            m_last,
  output logic [NSLAVES-1:0]             s_decerr
);

  localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int MW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

  logic [NSLAVES-1:0]               dec_hit;
  logic [MW-1:0]                    dec_idx [NSLAVES];
  logic [NMASTERS-1:0][NSLAVES-1:0] req;
  port_state_e                      st      [NMASTERS];
  logic [SW-1:0]                    gnt     [NMASTERS];
  logic [NMASTERS-1:0]              active;
  logic [NSLAVES-1:0]               owned;
  logic [NSLAVES-1:0]               drop;
  logic [NSLAVES-1:0]               drop_live;

  // Walk masters high to low so overlapping windows land on the lowest index.
  always_comb begin
    for (int s = 0; s < NSLAVES; s++) begin
      dec_hit[s] = 1'b0;
      dec_idx[s] = '0;
      if (HAS_DEST == 0) begin
        dec_hit[s] = 1'b1;
      end else begin
        for (int m = NMASTERS - 1; m >= 0; m--) begin
          if (dest_in_window(32'(s_dest[s*DEST_WIDTH +: DEST_WIDTH]), 32'(DEST_BASE),
                             32'(DEST_STRIDE), 32'(DEST_RANGE), 32'(m))) begin
            dec_hit[s] = 1'b1;
            dec_idx[s] = MW'(m);
          end
        end
      end
    end
  end

  // Slaves already owned by a master or being dropped never request again.
  always_comb begin
    owned = '0;
    for (int m = 0; m < NMASTERS; m++) begin
      if (active[m]) owned[gnt[m]] = 1'b1;
    end
    for (int m = 0; m < NMASTERS; m++) begin
      for (int s = 0; s < NSLAVES; s++) begin
        req[m][s] = aresetn && s_valid[s] && dec_hit[s] && (dec_idx[s] == MW'(m))
                    && !owned[s] && !drop[s];
      end
    end
  end

  for (genvar m = 0; m < NMASTERS; m++) begin : g_port
    axis_crossbar_master_port #(
      .NSLAVES  (NSLAVES),
      .HAS_LAST (HAS_LAST),
      .SW       (SW)
    ) u_port (
      .aclk    (aclk),
      .aresetn (aresetn),
      .req     (req[m]),
      .s_valid (s_valid),
      .s_last  (s_last),
      .m_ready (m_ready[m]),
      .state   (st[m]),
      .grant   (gnt[m])
    );
    assign active[m] = aresetn && (st[m] == TRANSACTION);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      drop <= '0;
    end else begin
      for (int s = 0; s < NSLAVES; s++) begin
        if (drop[s]) begin
          if (s_valid[s] && ((HAS_LAST == 0) || s_last[s])) drop[s] <= 1'b0;
        end else if (s_valid[s] && !dec_hit[s] && !owned[s]) begin
          drop[s] <= 1'b1;
        end
      end
    end
  end

  assign drop_live = drop & {NSLAVES{aresetn}};
  assign s_decerr  = drop_live & s_valid;

  always_comb begin
    int unsigned gi;
    gi      = 0;
    m_valid = '0;
    m_data  = '0;
    m_dest  = '0;
    m_id    = '0;
    m_last  = '0;
    s_ready = drop_live;
    for (int m = 0; m < NMASTERS; m++) begin
      gi = int'(gnt[m]);
      if (active[m]) begin
        m_valid[m] = s_valid[gi];
        m_data[m*DATA_WIDTH +: DATA_WIDTH] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
        if (HAS_DEST != 0) m_dest[m*DEST_WIDTH +: DEST_WIDTH] = s_dest[gi*DEST_WIDTH +: DEST_WIDTH];
        if (HAS_ID != 0)   m_id[m*ID_WIDTH +: ID_WIDTH]       = s_id[gi*ID_WIDTH +: ID_WIDTH];
        if (HAS_LAST != 0) m_last[m] = s_last[gi];
        if (m_ready[m])    s_ready[gi] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_switch_crossbar.sv
// Bench for axis_switch_crossbar: directed scenarios plus randomized packets
// scored against a per-slave expected-beat model.
module tb_axis_switch_crossbar;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [3:0]   s_valid = '0, s_ready, s_last = '0, s_id = '0, s_decerr;
  logic [255:0] s_data = '0, m_data;
  logic [31:0]  s_dest = '0, m_dest;
  logic [3:0]   m_valid, m_ready = '1, m_id, m_last;

  logic [3:0]   t_s_valid = '0, t_s_ready, t_s_last = '0, t_s_id = '0, t_s_decerr;
  logic [255:0] t_s_data = '0, t_m_data;
  logic [31:0]  t_s_dest = '0, t_m_dest;
  logic [3:0]   t_m_valid, t_m_ready = '1, t_m_id, t_m_last;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          m;
    logic [63:0] data;
    logic [7:0]  dest;
    logic        id;
    logic        last;
    int          cyc;
  } hs_t;

  hs_t         log_q[$];
  hs_t         mon_e;
  int          decerr_cnt[4];
  logic [64:0] exp_q[4][$];
  int          exp_drop[4];
  int          done_cnt;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axis_switch_crossbar dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest),
    .s_id(s_id), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dest(m_dest),
    .m_id(m_id), .m_last(m_last), .s_decerr(s_decerr)
  );

  axis_switch_crossbar #(.DEST_STRIDE(4), .DEST_RANGE(3)) dut_s (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(t_s_valid), .s_ready(t_s_ready), .s_data(t_s_data), .s_dest(t_s_dest),
    .s_id(t_s_id), .s_last(t_s_last),
    .m_valid(t_m_valid), .m_ready(t_m_ready), .m_data(t_m_data), .m_dest(t_m_dest),
    .m_id(t_m_id), .m_last(t_m_last), .s_decerr(t_s_decerr)
  );

  // Monitor: every master handshake and every decerr pulse, sampled mid-cycle.
  always @(negedge aclk) begin
    for (int m = 0; m < 4; m++) begin
      if (m_valid[m] && m_ready[m]) begin
        mon_e.m    = m;
        mon_e.data = m_data[m*64 +: 64];
        mon_e.dest = m_dest[m*8 +: 8];
        mon_e.id   = m_id[m];
        mon_e.last = m_last[m];
        mon_e.cyc  = cyc;
        log_q.push_back(mon_e);
      end
    end
    for (int s = 0; s < 4; s++) if (s_decerr[s]) decerr_cnt[s]++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] beat_word(input int s, input int dest, input int tag, input int b);
    return {16'(dest), 16'(tag), 16'(s), 16'(b)};
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = '0;
    s_last  = '0;
    m_ready = '1;
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    log_q.delete();
    for (int s = 0; s < 4; s++) decerr_cnt[s] = 0;
  endtask

  task automatic drive_pkt(input int s, input int dest, input int nbeats, input int tag);
    bit hs;
    int wait_cyc;
    for (int b = 0; b < nbeats; b++) begin
      s_valid[s]         = 1'b1;
      s_dest[s*8 +: 8]   = 8'(dest);
      s_data[s*64 +: 64] = beat_word(s, dest, tag, b);
      s_last[s]          = (b == nbeats - 1);
      s_id[s]            = 1'($urandom);
      hs       = 1'b0;
      wait_cyc = 0;
      while (!hs && wait_cyc < 300) begin
        @(negedge aclk);
        hs = s_valid[s] && s_ready[s];
        step();
        wait_cyc++;
      end
      checks++;
      if (!hs) begin
        failures++;
        $display("FAIL drive_timeout slave=%0d beat=%0d got no handshake, required one within 300 cycles", s, b);
      end
    end
    s_valid[s] = 1'b0;
    s_last[s]  = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_valid = '1;
    s_last  = '1;
    s_dest  = '0;
    s_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    m_ready = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      checks++;
      if ({m_valid, s_ready, s_decerr, m_data, m_dest, m_id, m_last} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got valid=%b ready=%b decerr=%b data=%h required all zero", i, m_valid, s_ready, s_decerr, m_data);
      end
      step();
    end
    s_valid = '0;
    s_last  = '0;
    aresetn = 1'b1;
    step();
    @(negedge aclk);
    checks++;
    if ({m_valid, s_ready, s_decerr, m_data, m_dest, m_id, m_last} !== '0) begin
      failures++;
      $display("FAIL post_reset_idle got valid=%b ready=%b decerr=%b required all zero", m_valid, s_ready, s_decerr);
    end
    step();
  endtask

  task automatic test_concurrent();
    int start;
    hs_t e;
    do_reset();
    start = cyc;
    fork
      drive_pkt(0, 2, 3, 1);
      drive_pkt(1, 0, 3, 2);
      begin
        @(negedge aclk);
        checks++;
        if ({m_valid, s_ready} !== '0) begin
          failures++;
          $display("FAIL conc_arb_cycle got m_valid=%b s_ready=%b required 0/0", m_valid, s_ready);
        end
      end
    join
    checks++;
    if (log_q.size() != 6) begin
      failures++;
      $display("FAIL conc_count got %0d beats required 6", log_q.size());
    end else begin
      for (int b = 0; b < 3; b++) begin
        e = log_q[2*b];
        checks++;
        if (e.m != 0 || e.data !== beat_word(1, 0, 2, b) || e.last !== (b == 2) || e.cyc != start + 1 + b) begin
          failures++;
          $display("FAIL conc_m0 beat=%0d got m=%0d data=%h last=%b cyc=%0d required m=0 data=%h last=%b cyc=%0d",
                   b, e.m, e.data, e.last, e.cyc - start, beat_word(1, 0, 2, b), b == 2, 1 + b);
        end
        e = log_q[2*b+1];
        checks++;
        if (e.m != 2 || e.data !== beat_word(0, 2, 1, b) || e.last !== (b == 2) || e.cyc != start + 1 + b) begin
          failures++;
          $display("FAIL conc_m2 beat=%0d got m=%0d data=%h last=%b cyc=%0d required m=2 data=%h last=%b cyc=%0d",
                   b, e.m, e.data, e.last, e.cyc - start, beat_word(0, 2, 1, b), b == 2, 1 + b);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int start;
    hs_t e;
    do_reset();
    start = cyc;
    fork
      begin drive_pkt(0, 1, 1, 10); drive_pkt(0, 1, 1, 11); end
      drive_pkt(1, 1, 1, 10);
      drive_pkt(2, 1, 1, 10);
      drive_pkt(3, 1, 1, 10);
    join
    checks++;
    if (log_q.size() != 5) begin
      failures++;
      $display("FAIL rr_count got %0d packets required 5", log_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        e = log_q[k];
        checks++;
        if (e.m != 1 || int'(e.data[31:16]) != k % 4 || e.cyc != start + 1 + 2*k) begin
          failures++;
          $display("FAIL rr_order k=%0d got m=%0d src=%0d cyc=%0d required m=1 src=%0d cyc=%0d",
                   k, e.m, e.data[31:16], e.cyc - start, k % 4, 1 + 2*k);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    bit pkt_done;
    int g;
    do_reset();
    pkt_done = 1'b0;
    g = 0;
    fork
      begin drive_pkt(2, 8'h40, 3, 5); pkt_done = 1'b1; end
      while (!pkt_done && g < 50) begin
        @(negedge aclk);
        checks++;
        if (m_valid !== '0 || s_decerr[2] !== (s_valid[2] && s_ready[2]) || s_decerr[3] !== 1'b0) begin
          failures++;
          $display("FAIL unmapped_cycle got m_valid=%b decerr=%b s_ready=%b required m_valid=0 decerr on accepted beats",
                   m_valid, s_decerr, s_ready);
        end
        step();
        g++;
      end
    join
    checks++;
    if (decerr_cnt[2] != 3 || log_q.size() != 0) begin
      failures++;
      $display("FAIL unmapped_totals got decerr=%0d beats_out=%0d required 3 and 0", decerr_cnt[2], log_q.size());
    end
    drive_pkt(2, 3, 2, 6);
    checks++;
    if (log_q.size() != 2 || log_q[0].m != 3 || log_q[1].data !== beat_word(2, 3, 6, 1) || decerr_cnt[2] != 3) begin
      failures++;
      $display("FAIL unmapped_then_mapped got %0d beats decerr=%0d required 2 beats on M3, decerr 3", log_q.size(), decerr_cnt[2]);
    end
  endtask

  task automatic test_backpressure();
    int start;
    int exp_cyc[4] = '{1, 7, 8, 9};
    do_reset();
    start = cyc;
    fork
      drive_pkt(1, 3, 4, 7);
      begin
        step();
        step();
        m_ready[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge aclk);
          checks++;
          if ({s_ready[1], m_valid[3], m_data[192 +: 64]} !== {1'b0, 1'b1, beat_word(1, 3, 7, 1)}) begin
            failures++;
            $display("FAIL stall_cycle i=%0d got s_ready=%b m_valid=%b data=%h required 0 1 %h",
                     i, s_ready[1], m_valid[3], m_data[192 +: 64], beat_word(1, 3, 7, 1));
          end
          step();
        end
        m_ready[3] = 1'b1;
      end
    join
    checks++;
    if (log_q.size() != 4) begin
      failures++;
      $display("FAIL stall_count got %0d beats required 4", log_q.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (log_q[b].m != 3 || log_q[b].data !== beat_word(1, 3, 7, b) || log_q[b].cyc != start + exp_cyc[b]) begin
          failures++;
          $display("FAIL stall_beat b=%0d got m=%0d data=%h cyc=%0d required m=3 data=%h cyc=%0d",
                   b, log_q[b].m, log_q[b].data, log_q[b].cyc - start, beat_word(1, 3, 7, b), exp_cyc[b]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int start;
    int exp_cyc[4] = '{1, 5, 6, 7};
    do_reset();
    start = cyc;
    fork
      drive_pkt(0, 1, 4, 9);
      begin
        step();
        step();
        aresetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
          @(negedge aclk);
          checks++;
          if ({m_valid, s_ready, s_decerr, m_data, m_last} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs i=%0d got m_valid=%b s_ready=%b required 0", i, m_valid, s_ready);
          end
          step();
        end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if ({m_valid, s_ready} !== '0) begin
          failures++;
          $display("FAIL midreset_rearb got m_valid=%b s_ready=%b required 0", m_valid, s_ready);
        end
        step();
        @(negedge aclk);
        checks++;
        if ({m_valid, m_data[64 +: 64]} !== {4'b0010, beat_word(0, 1, 9, 1)}) begin
          failures++;
          $display("FAIL midreset_resume got m_valid=%b data=%h required 0010 %h", m_valid, m_data[64 +: 64], beat_word(0, 1, 9, 1));
        end
      end
    join
    checks++;
    if (log_q.size() != 4) begin
      failures++;
      $display("FAIL midreset_count got %0d beats required 4", log_q.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (log_q[b].m != 1 || log_q[b].data !== beat_word(0, 1, 9, b) || log_q[b].last !== (b == 3) || log_q[b].cyc != start + exp_cyc[b]) begin
          failures++;
          $display("FAIL midreset_beat b=%0d got m=%0d data=%h cyc=%0d required m=1 data=%h cyc=%0d",
                   b, log_q[b].m, log_q[b].data, log_q[b].cyc - start, beat_word(0, 1, 9, b), exp_cyc[b]);
        end
      end
    end
  endtask

  task automatic test_stride();
    int dests[3] = '{7, 3, 12};
    for (int i = 0; i < 3; i++) begin
      int d;
      int mi;
      logic [3:0] exp_mv;
      d      = dests[i];
      mi     = d / 4;
      exp_mv = 4'(1 << mi);
      t_s_valid[0]     = 1'b1;
      t_s_last[0]      = 1'b1;
      t_s_dest[7:0]    = 8'(d);
      t_s_data[63:0]   = beat_word(0, d, i, 0);
      t_m_ready        = '1;
      step();
      @(negedge aclk);
      checks++;
      if ({t_m_valid, t_s_ready[0], t_m_dest[mi*8 +: 8], t_m_data[mi*64 +: 64]} !== {exp_mv, 1'b1, 8'(d), beat_word(0, d, i, 0)}) begin
        failures++;
        $display("FAIL stride_route dest=%0d got m_valid=%b s_ready=%b required m_valid=%b s_ready=1",
                 d, t_m_valid, t_s_ready[0], exp_mv);
      end
      step();
      t_s_valid[0] = 1'b0;
      t_s_last[0]  = 1'b0;
      step();
    end
  endtask

  task automatic random_slave(input int s);
    for (int p = 0; p < 6; p++) begin
      int nb;
      int d;
      nb = $urandom_range(1, 4);
      d  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : 8'h40 + $urandom_range(0, 15);
      if (d < 4) begin
        for (int b = 0; b < nb; b++) exp_q[s].push_back({b == nb - 1, beat_word(s, d, p + 16, b)});
      end else begin
        exp_drop[s] += nb;
      end
      drive_pkt(s, d, nb, p + 16);
      repeat ($urandom_range(0, 2)) step();
    end
    done_cnt++;
  endtask

  task automatic test_random();
    int open_src[4];
    int g;
    int src;
    int dst;
    bit ok;
    logic [64:0] exp_e;
    hs_t e;
    do_reset();
    done_cnt = 0;
    g = 0;
    for (int s = 0; s < 4; s++) begin
      exp_q[s].delete();
      exp_drop[s] = 0;
      open_src[s] = -1;
    end
    fork
      random_slave(0);
      random_slave(1);
      random_slave(2);
      random_slave(3);
      begin
        while (done_cnt < 4 && g < 6000) begin
          m_ready = 4'($urandom);
          step();
          g++;
        end
        m_ready = '1;
      end
    join
    foreach (log_q[i]) begin
      e   = log_q[i];
      src = int'(e.data[31:16]);
      dst = int'(e.data[63:48]);
      ok  = 1'b0;
      if (src < 4) begin
        if (exp_q[src].size() > 0) begin
          exp_e = exp_q[src].pop_front();
          ok = ({e.last, e.data} === exp_e) && (e.m == dst) && (e.dest === 8'(dst)) && (e.id === 1'b0)
               && (open_src[e.m] < 0 || open_src[e.m] == src);
        end
      end
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_beat i=%0d got m=%0d data=%h dest=%h last=%b required next beat of slave %0d on master %0d, unbroken packet",
                 i, e.m, e.data, e.dest, e.last, src, dst);
      end
      open_src[e.m] = e.last ? -1 : src;
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (exp_q[s].size() != 0 || decerr_cnt[s] != exp_drop[s]) begin
        failures++;
        $display("FAIL rand_totals slave=%0d got undelivered=%0d decerr=%0d required 0 and %0d",
                 s, exp_q[s].size(), decerr_cnt[s], exp_drop[s]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_concurrent();
    test_round_robin();
    test_unmapped();
    test_backpressure();
    test_reset_mid_packet();
    test_stride();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
